// File: rtl/reg_init_loader_if.sv
// Word stream in, register-file initialise-write port out.
interface reg_init_loader_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              init_we;
  logic [ADDR_W-1:0] init_addr;
  logic [DATA_W-1:0] init_data;

  modport slave  (input  in_valid, in_data, output in_ready, init_we, init_addr, init_data);
  modport master (output in_valid, in_data, input  in_ready, init_we, init_addr, init_data);
endinterface

// File: rtl/reg_init_loader.sv
// Boot/on-demand loader: streams NUM_REGS words into consecutive register
// file addresses through the initialise-write port, stalling the core meanwhile.
module reg_init_loader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_R0  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  reg_init_loader_if.slave    bus,
  output logic [ADDR_W:0]     load_count,
  output logic                busy,
  output logic                done,
  output logic                cpu_hold
);
  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_REGS - 1);

  state_t            r_state, w_next;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W:0]   r_load_count;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_data;
  logic              w_ready, w_accept, w_restart;

  assign w_accept  = bus.in_valid & w_ready;
  assign w_restart = start & ((r_state == IDLE) | (r_state == DONE));

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = LOAD;
      LOAD: begin
        w_ready = 1'b1;
        if (bus.in_valid && r_cnt == LAST) w_next = FLUSH;
      end
      FLUSH: w_next = DONE;
      DONE:  if (start) w_next = LOAD;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_load_count <= '0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
    end else begin
      r_state <= w_next;
      // Write is registered: the accept edge is followed by exactly one write cycle.
      r_we    <= w_accept;
      if (w_restart) begin
        r_cnt        <= '0;
        r_load_count <= '0;
      end else if (w_accept) begin
        r_addr       <= r_cnt;
        r_data       <= (ZERO_R0 != 0 && r_cnt == '0) ? '0 : bus.in_data;
        r_cnt        <= r_cnt + 1'b1;
        r_load_count <= r_load_count + 1'b1;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.init_we   = r_we;
  assign bus.init_addr = r_addr;
  assign bus.init_data = r_data;
  assign load_count    = r_load_count;
  assign busy          = (r_state == LOAD) || (r_state == FLUSH);
  assign done          = (r_state == DONE);
  assign cpu_hold      = busy;
endmodule

// File: tb/tb_reg_init_loader.sv
// Scoreboarded bench for reg_init_loader with a behavioural register file.
module tb_reg_init_loader;
  logic clk = 1'b0;
  logic rst, start, start2;
  logic [5:0] load_count, load_count2;
  logic busy, done, cpu_hold, busy2, done2, cpu_hold2;
  logic [31:0] rf [32];
  logic [31:0] rf2 [32];
  logic [36:0] exp_q [$];
  int errors = 0;
  int checks = 0;

  reg_init_loader_if #(.ADDR_W(5), .DATA_W(32)) bus ();
  reg_init_loader_if #(.ADDR_W(5), .DATA_W(32)) bus2 ();

  reg_init_loader #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(32), .ZERO_R0(1)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .load_count(load_count), .busy(busy), .done(done), .cpu_hold(cpu_hold));

  reg_init_loader #(.NUM_REGS(4), .ADDR_W(5), .DATA_W(32), .ZERO_R0(0)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .bus(bus2),
    .load_count(load_count2), .busy(busy2), .done(done2), .cpu_hold(cpu_hold2));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.init_we === 1'b1)  rf[bus.init_addr]   <= bus.init_data;
    if (bus2.init_we === 1'b1) rf2[bus2.init_addr] <= bus2.init_data;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Monitor: every presented write must match the oldest expected write.
  always @(negedge clk) begin
    logic [36:0] e;
    if (bus.init_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write addr=%0d data=%h required=none", bus.init_addr, bus.init_data);
      end else begin
        e = exp_q.pop_front();
        chk("write", {27'd0, bus.init_addr, bus.init_data}, {27'd0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  // Present one word and wait (bounded) for it to be accepted.
  task automatic send(input logic [31:0] d, input logic [4:0] ea, input logic [31:0] ed);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        exp_q.push_back({ea, ed});
        tick();
        break;
      end
      n++;
      if (n > 20) begin
        chk("accept_timeout", 64'd0, 64'd1);
        tick();
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (done !== 1'b1 && n < 50) begin tick(); n++; end
    chk("done_reached", {63'd0, done}, 64'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start2 = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0;
    bus2.in_valid = 1'b0; bus2.in_data = '0;
    tick(); tick();
    chk("rst_outputs", {bus.in_ready, bus.init_we, bus.init_addr, bus.init_data, load_count, busy, done, cpu_hold}, 64'd0);
    rst = 1'b0;
    tick();
    chk("idle_ready", {63'd0, bus.in_ready}, 64'd0);

    // Continuous stream, address 0 forced to zero
    pulse_start();
    chk("load_busy", {62'd0, busy, cpu_hold}, 64'd3);
    for (int i = 0; i < 32; i++)
      send(32'h1000_0000 + i, 5'(i), (i == 0) ? 32'h0 : 32'h1000_0000 + i);
    bus.in_valid = 1'b0;
    chk("flush_state", {58'd0, bus.init_we, bus.in_ready, busy, done, bus.init_addr == 5'd31, 1'b0}, {58'd0, 6'b101010});
    tick();
    chk("done_rise", {61'd0, done, busy, bus.init_we}, 64'd4);
    chk("load_count32", {58'd0, load_count}, 64'd32);
    chk("rf5", {32'd0, rf[5]}, 64'h1000_0005);
    chk("rf0_zero", {32'd0, rf[0]}, 64'h0);

    // Stalled stream: valid 1,0,0,1,...
    pulse_start();
    chk("done_clear", {63'd0, done}, 64'd0);
    for (int i = 0; i < 32; i++) begin
      send(32'h2000_0000 + i, 5'(i), (i == 0) ? 32'h0 : 32'h2000_0000 + i);
      if (i < 31) begin
        bus.in_valid = 1'b0;
        for (int g = 0; g < 2; g++) begin
          @(negedge clk);
          if (i % 8 == 0) chk("gap_busy", {62'd0, busy, cpu_hold}, 64'd3);
          tick();
        end
      end
    end
    bus.in_valid = 1'b0;
    wait_done();
    chk("rf17_gap", {32'd0, rf[17]}, 64'h2000_0011);

    // Reset after 10 accepts
    pulse_start();
    for (int i = 0; i < 10; i++)
      send(32'h3000_0000 + i, 5'(i), (i == 0) ? 32'h0 : 32'h3000_0000 + i);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_state", {58'd0, bus.init_we, busy, done, bus.in_ready, cpu_hold, 1'b0}, 64'd0);
    chk("midrst_count", {58'd0, load_count}, 64'd0);
    chk("rf1_kept", {32'd0, rf[1]}, 64'h3000_0001);
    chk("rf9_kept", {32'd0, rf[9]}, 64'h3000_0009);
    chk("rf10_old", {32'd0, rf[10]}, 64'h2000_000A);

    // start pulsed mid-load is ignored
    pulse_start();
    for (int i = 0; i < 32; i++) begin
      if (i == 7) start = 1'b1;
      send(32'h4000_0000 + i, 5'(i), (i == 0) ? 32'h0 : 32'h4000_0000 + i);
      start = 1'b0;
    end
    bus.in_valid = 1'b0;
    wait_done();
    chk("reload_count", {58'd0, load_count}, 64'd32);
    chk("rf31_reload", {32'd0, rf[31]}, 64'h4000_001F);

    // All-ones reload, valid held after final accept
    pulse_start();
    for (int i = 0; i < 32; i++)
      send(32'hFFFF_FFFF, 5'(i), (i == 0) ? 32'h0 : 32'hFFFF_FFFF);
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      chk("no_ready_after", {63'd0, bus.in_ready}, 64'd0);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("ones_done", {63'd0, done}, 64'd1);
    chk("rf31_ones", {32'd0, rf[31]}, 64'hFFFF_FFFF);
    chk("rf0_ones_zero", {32'd0, rf[0]}, 64'h0);
    chk("ones_count", {58'd0, load_count}, 64'd32);

    // ZERO_R0=0 build with 4 registers
    start2 = 1'b1; tick(); start2 = 1'b0;
    bus2.in_valid = 1'b1;
    bus2.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("dut2_ready", {63'd0, bus2.in_ready}, 64'd1);
      tick();
      bus2.in_data = 32'(i + 1);
    end
    bus2.in_valid = 1'b0;
    tick();
    chk("dut2_done", {63'd0, done2}, 64'd1);
    chk("dut2_count", {58'd0, load_count2}, 64'd4);
    chk("dut2_rf0", {32'd0, rf2[0]}, 64'hDEAD_BEEF);
    chk("dut2_rf3", {32'd0, rf2[3]}, 64'h3);

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_init_loader.md
Name: reg_init_loader

Overview:
- Sequencer that fills the 32x32 register file at boot, or on demand, from a valid/ready word stream. Typical sources are a testbench, a boot ROM reader or a UART bridge.
- Drives the register file's initialise-write port: WriteInitialiseSignal, WriteInitialiseAdd and WriteInitialiseData.
- Asserts cpu_hold while loading, so the core issues no write-back during the load.
- Writes to consecutive addresses with one registered write per accepted word.

Parameters:
- NUM_REGS, 32, number of registers loaded per sequence (1..2^ADDR_W).
- ADDR_W, 5, register address width.
- DATA_W, 32, register data width.
- ZERO_R0, 1, when 1 the word for address 0 is consumed but written as all-zeros (MIPS $zero).

Ports:
- clk  input  1  rising-edge clock, shared with the register file.
- rst  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request to begin a load sequence.
- in_valid  input  1  source has a word on in_data.
- in_data  input  DATA_W  word for the current address.
- in_ready  output  1  loader accepts in_data this cycle.
- init_we  output  1  to WriteInitialiseSignal.
- init_addr  output  ADDR_W  to WriteInitialiseAdd.
- init_data  output  DATA_W  to WriteInitialiseData.
- load_count  output  ADDR_W+1  number of words accepted in the current/last sequence.
- busy  output  1  sequence in progress, including the final write cycle.
- done  output  1  last sequence completed; held high.
- cpu_hold  output  1  stall request to the core; equal to busy.

Behaviour:
- Clock and reset:
  - Only clock is clk, only reset is rst. rst is synchronous, active-high; all state updates on the rising edge of clk.
- Reset values:
  - State IDLE, counter 0.
  - in_ready=0, init_we=0, init_addr=0, init_data=0.
  - load_count=0, busy=0, done=0, cpu_hold=0.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE:
  - in_ready=0.
  - start=1 -> LOAD, counter<=0, load_count<=0.
- LOAD:
  - in_ready=1 combinationally in LOAD only; in_data and in_valid are not required to be stable outside a handshake.
  - Accept occurs when in_valid&in_ready. On accept, next edge: init_we<=1, init_addr<=counter, init_data<=(ZERO_R0 && counter==0) ? 0 : in_data, counter<=counter+1, load_count<=load_count+1.
  - Cycle with no accept: init_we<=0 at the next edge. The source may stall arbitrarily.
  - Accept with counter==NUM_REGS-1 -> FLUSH.
- FLUSH:
  - One cycle. in_ready=0. The final registered write is presented (init_we=1).
  - Next edge -> DONE with init_we<=0.
- DONE:
  - done=1, in_ready=0, init_we=0.
  - start=1 -> LOAD: done<=0, counter<=0, load_count<=0 (reload supported).
- busy and cpu_hold:
  - busy=1 in LOAD and FLUSH; cpu_hold=busy.
  - busy falls on the same edge that done rises.
- start handling:
  - start in LOAD or FLUSH is ignored; the sequence is not restarted.
  - start and rst in the same cycle: rst wins.
- Write timing:
  - Latency from accept to write is exactly 1 cycle: the word accepted at edge N is written into the register file at edge N+1.
  - Back-to-back accepts give one write per cycle, with addresses strictly increasing from 0 and no gaps or repeats.
- Wrap-around:
  - counter never exceeds NUM_REGS-1 at write time.
  - in_valid held high after the last accept is not consumed (in_ready=0).
- Reset mid-sequence:
  - Returns to IDLE at that edge; init_we=0 from that edge onward.
  - Registers already written keep their values; done stays 0.
  - A new start reloads from address 0.
- Write-port conflicts: the register file gives the initialise write priority over write-back. cpu_hold exists so the core suppresses write-back; the loader does not check for conflicts itself.

Test Plan:
- Reset then start; in_valid held 1 with in_data=0x1000_0000+i for i=0..31 -> 32 consecutive init_we pulses. init_addr=0..31 with data 0x1000_0000+i, except address 0 written as 0x0000_0000 (ZERO_R0=1). done rises one cycle after the last write; load_count=32; register file reads Reg[5]=0x1000_0005.
- Same stream with in_valid toggled 1,0,0,1,... -> writes only follow accepts; no address skipped or repeated; busy and cpu_hold held 1 throughout, including the idle gaps.
- rst asserted after 10 accepts -> init_we=0 from that edge, state IDLE, done=0. Reg[1..9] retain the loaded values. A new start writes again from address 0.
- start pulsed at accept 7 of a running load -> ignored; the sequence completes with 32 writes and addresses continue from 7.
- After done, pulse start and stream 0xFFFF_FFFF for all words -> done clears, and Reg[31]=0xFFFF_FFFF on completion. in_valid held 1 after the final accept -> in_ready=0 and no 33rd write.
- ZERO_R0=0 build, word 0 = 0xDEAD_BEEF -> Reg[0]=0xDEAD_BEEF.
